sobel_window_stage: RTL

- Downstream consumer of the 3x3 window mux pair that reads the dual line BRAMs and presents nine 8-bit pixels per cycle.
- Computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline, saturates it to 8 bits and thresholds it to an edge flag.
- Counts output beats per frame, flags the last beat, and reports the edge-pixel count for the frame.
- Feeds the result write-back / external memory stage.

---
 rtl/sobel_window_stage_pkg.sv | 18 +
 rtl/sobel_frame_counter.sv | 58 +++++
 rtl/sobel_window_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sobel_window_stage_pkg.sv
// Shared widths, defaults and helpers for the Sobel window stage.
package sobel_window_stage_pkg;

  localparam int unsigned PIX_W_DEF     = 8;
  localparam int unsigned GRAD_W        = 11;
  localparam int unsigned SUM_W         = 11;
  localparam int unsigned CNT_W         = 12;
  localparam int unsigned FRAME_PIX_DEF = 36;  // 3x3 positions in an 8x8 image
  localparam int unsigned THRESH_DEF    = 128;

  // Magnitude of a signed gradient; -1020 is the most negative value, so no overflow.
  function automatic logic [SUM_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] neg_g;
    neg_g = -g;
    return g[GRAD_W-1] ? SUM_W'(unsigned'(neg_g)) : SUM_W'(unsigned'(g));
  endfunction

endpackage

// File: rtl/sobel_frame_counter.sv
// Per-frame beat counter, last-beat flag and edge-pixel accumulator.
module sobel_frame_counter
  import sobel_window_stage_pkg::*;
#(
  parameter int unsigned FRAME_PIX = FRAME_PIX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             beat_valid,
  input  logic             beat_hs,
  input  logic             beat_edge,
  output logic             last_c,
  output logic [CNT_W-1:0] edge_count
);

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;

  // Next-state for counters; start wins over a handshake but never blocks edge_count.
  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    last_c       = beat_valid && (pix_cnt_q == CNT_W'(FRAME_PIX - 1));
    if (beat_hs) begin
      if (last_c) begin
        pix_cnt_d    = '0;
        acc_d        = '0;
        edge_count_d = acc_q + CNT_W'(beat_edge);
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
        acc_d     = acc_q + CNT_W'(beat_edge);
      end
    end
    if (start) begin
      pix_cnt_d = '0;
      acc_d     = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      acc_q        <= '0;
      edge_count_q <= '0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;

endmodule

// File: rtl/sobel_window_stage.sv
// 3-stage Sobel |Gx|+|Gy| pipeline with saturation, threshold and frame accounting.
module sobel_window_stage
  import sobel_window_stage_pkg::*;
#(
  parameter int unsigned PIX_W     = PIX_W_DEF,
  parameter int unsigned FRAME_PIX = FRAME_PIX_DEF,
  parameter int unsigned THRESH    = THRESH_DEF
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             win_valid,
  output logic             win_ready,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] mag,
  output logic             edge_flag,
  output logic             out_last,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
);

  localparam int unsigned MAG_MAX = (1 << PIX_W) - 1;

  // Weighted 1-2-1 tap sum of three pixels, zero-extended to gradient width.
  function automatic logic [GRAD_W-1:0] tap3(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  logic                     advance_c;
  logic                     hs_c;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [GRAD_W-1:0] gx_q, gx_d;
  logic signed [GRAD_W-1:0] gy_q, gy_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic                     out_valid_q, out_valid_d;
  logic [PIX_W-1:0]         mag_q, mag_d;
  logic                     edge_q, edge_d;

  // Pipeline next-state; one global stall freezes every stage including outputs.
  always_comb begin
    advance_c   = !out_valid_q || out_ready;
    s1_valid_d  = s1_valid_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    s2_valid_d  = s2_valid_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    mag_d       = mag_q;
    edge_d      = edge_q;
    if (advance_c) begin
      s1_valid_d = win_valid;
      if (win_valid) begin
        gx_d = signed'(tap3(p3, p6, p9) - tap3(p1, p4, p7));
        gy_d = signed'(tap3(p7, p8, p9) - tap3(p1, p2, p3));
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d = grad_abs(gx_q) + grad_abs(gy_q);
      end
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        mag_d  = (sum_q > SUM_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : sum_q[PIX_W-1:0];
        edge_d = (mag_d >= PIX_W'(THRESH));
      end
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q  <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      s2_valid_q  <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      edge_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      s2_valid_q  <= s2_valid_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      edge_q      <= edge_d;
    end
  end

  assign hs_c = out_valid_q && out_ready;

  sobel_frame_counter #(
    .FRAME_PIX (FRAME_PIX)
  ) u_frame_counter (
    .clk        (clk),
    .rst_n      (RESET_N),
    .start      (start),
    .beat_valid (out_valid_q),
    .beat_hs    (hs_c),
    .beat_edge  (edge_q),
    .last_c     (out_last),
    .edge_count (edge_count)
  );

  assign win_ready = advance_c;
  assign out_valid = out_valid_q;
  assign mag       = mag_q;
  assign edge_flag = edge_q;
  assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

endmodule
